// File: rtl/ps2_letter_tx.sv
// PS/2 device-side transmitter: turns a letter index (A..Z) into Set-2 scan-code frames with a self-generated PS/2 clock.
// Define PS2_TX_BREAK_EN to send make, F0, make (full press/release); otherwise only the make code is sent.
module ps2_letter_tx #(
  parameter int CLK_DIV = 2500,
  parameter int GAP     = 5000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [4:0] letter,
  input  logic       send,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic       ps2_clk_o,
  output logic       ps2_dat_o
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
`ifdef PS2_TX_BREAK_EN
  localparam logic [1:0] LAST_FRAME = 2'd2;
`else
  localparam logic [1:0] LAST_FRAME = 2'd0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  function automatic logic [7:0] scan_code(input logic [4:0] idx);
    case (idx)
      5'd0:    scan_code = 8'h1C;
      5'd1:    scan_code = 8'h32;
      5'd2:    scan_code = 8'h21;
      5'd3:    scan_code = 8'h23;
      5'd4:    scan_code = 8'h24;
      5'd5:    scan_code = 8'h2B;
      5'd6:    scan_code = 8'h34;
      5'd7:    scan_code = 8'h33;
      5'd8:    scan_code = 8'h43;
      5'd9:    scan_code = 8'h3B;
      5'd10:   scan_code = 8'h42;
      5'd11:   scan_code = 8'h4B;
      5'd12:   scan_code = 8'h3A;
      5'd13:   scan_code = 8'h31;
      5'd14:   scan_code = 8'h44;
      5'd15:   scan_code = 8'h4D;
      5'd16:   scan_code = 8'h15;
      5'd17:   scan_code = 8'h2D;
      5'd18:   scan_code = 8'h1B;
      5'd19:   scan_code = 8'h2C;
      5'd20:   scan_code = 8'h3C;
      5'd21:   scan_code = 8'h2A;
      5'd22:   scan_code = 8'h1D;
      5'd23:   scan_code = 8'h22;
      5'd24:   scan_code = 8'h35;
      5'd25:   scan_code = 8'h1A;
      default: scan_code = 8'h00;
    endcase
  endfunction

  function automatic logic odd_parity(input logic [7:0] b);
    odd_parity = ~(^b);
  endfunction

  // Bit 0 is the start bit; bit 10 is the stop bit.
  function automatic logic [10:0] frame_word(input logic [7:0] b);
    frame_word = {1'b1, odd_parity(b), b, 1'b0};
  endfunction

  state_t          state, state_nxt;
  logic [HW-1:0]   half_cnt, half_nxt;
  logic            low_half, low_nxt;
  logic [3:0]      bit_idx, bit_nxt;
  logic [1:0]      frame_idx, frame_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [7:0]      code, code_nxt;
  logic [7:0]      data_nxt;
  logic [10:0]     word_nxt;
  logic            ready_nxt, done_nxt, err_nxt, clk_nxt, dat_nxt;

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_nxt = state;
    half_nxt  = half_cnt;
    low_nxt   = low_half;
    bit_nxt   = bit_idx;
    frame_nxt = frame_idx;
    gap_nxt   = gap_cnt;
    code_nxt  = code;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        half_nxt  = '0;
        low_nxt   = 1'b0;
        bit_nxt   = 4'd0;
        frame_nxt = 2'd0;
        gap_nxt   = '0;
        if (send) begin
          if (letter <= 5'd25) begin
            code_nxt  = scan_code(letter);
            state_nxt = S_FRAME;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FRAME: begin
        if (half_cnt == HALF_LAST) begin
          half_nxt = '0;
          if (low_half) begin
            low_nxt = 1'b0;
            if (bit_idx == 4'd10) begin
              bit_nxt = 4'd0;
              if (frame_idx == LAST_FRAME) begin
                state_nxt = S_IDLE;
                frame_nxt = 2'd0;
                done_nxt  = 1'b1;
              end else begin
                state_nxt = S_GAP;
                frame_nxt = frame_idx + 2'd1;
                gap_nxt   = '0;
              end
            end else begin
              bit_nxt = bit_idx + 4'd1;
            end
          end else begin
            low_nxt = 1'b1;
          end
        end else begin
          half_nxt = half_cnt + HW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = S_FRAME;
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // The middle frame of a break sequence carries the F0 prefix.
    if (frame_nxt == 2'd1) begin
      data_nxt = 8'hF0;
    end else begin
      data_nxt = code_nxt;
    end
    word_nxt  = frame_word(data_nxt);
    ready_nxt = (state_nxt == S_IDLE);
    if (state_nxt == S_FRAME) begin
      clk_nxt = ~low_nxt;
      dat_nxt = word_nxt[bit_nxt];
    end else begin
      clk_nxt = 1'b1;
      dat_nxt = 1'b1;
    end
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= S_IDLE;
      half_cnt  <= '0;
      low_half  <= 1'b0;
      bit_idx   <= 4'd0;
      frame_idx <= 2'd0;
      gap_cnt   <= '0;
      code      <= 8'h00;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      ps2_clk_o <= 1'b1;
      ps2_dat_o <= 1'b1;
    end else begin
      state     <= state_nxt;
      half_cnt  <= half_nxt;
      low_half  <= low_nxt;
      bit_idx   <= bit_nxt;
      frame_idx <= frame_nxt;
      gap_cnt   <= gap_nxt;
      code      <= code_nxt;
      ready     <= ready_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      ps2_clk_o <= clk_nxt;
      ps2_dat_o <= dat_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_letter_tx.sv
// Directed self-checking bench for ps2_letter_tx with CLK_DIV=4, GAP=8; adapts to PS2_TX_BREAK_EN.
module tb_ps2_letter_tx;

`ifdef PS2_TX_BREAK_EN
  localparam int NF       = 3;
  localparam int DONE_CYC = 281;
  localparam int RST_CYC  = 122;
`else
  localparam int NF       = 1;
  localparam int DONE_CYC = 89;
  localparam int RST_CYC  = 30;
`endif
  localparam int LIMIT = 400;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] letter;
  logic       send;
  logic       ready, done, err, ps2_clk_o, ps2_dat_o;

  int n_checks = 0;
  int n_errors = 0;

  ps2_letter_tx #(.CLK_DIV(4), .GAP(8)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .letter   (letter),
    .send     (send),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .ps2_clk_o(ps2_clk_o),
    .ps2_dat_o(ps2_dat_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request a letter: send is raised before edge 0 and the caller is left just after that edge.
  task automatic request(input logic [4:0] l);
    @(negedge clk);
    letter = l;
    send   = 1'b1;
    @(posedge clk);
  endtask

  // Follow one sequence from cycle 1 to done, decoding frames on falling ps2_clk_o edges.
  task automatic watch_seq(input string nm, input logic [7:0] mk, input logic mk_par, input bit keep_send);
    logic [10:0] sh;
    logic [10:0] frames [3];
    logic [10:0] expw;
    logic        pclk, pdat;
    int nbits, nfr, done_cyc, first_fall, bad_edge;
    sh = '0; nbits = 0; nfr = 0; done_cyc = 0; first_fall = 0; bad_edge = 0;
    pclk = 1'b1; pdat = 1'b1;
    for (int i = 0; i < 3; i++) frames[i] = '0;
    for (int cyc = 1; cyc <= LIMIT; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check_val({nm, "_ready_drop"}, ready, 1'b0);
        check_val({nm, "_start_bit"}, ps2_dat_o, 1'b0);
        if (!keep_send) send = 1'b0;
      end
      if (pclk == 1'b1 && ps2_clk_o == 1'b0) begin
        if (first_fall == 0) first_fall = cyc;
        sh = {ps2_dat_o, sh[10:1]};
        nbits++;
        if (nbits == 11) begin
          if (nfr < 3) frames[nfr] = sh;
          nfr++;
          nbits = 0;
        end
      end
      if (pclk == 1'b0 && ps2_clk_o == 1'b0 && ps2_dat_o != pdat) bad_edge++;
      pclk = ps2_clk_o;
      pdat = ps2_dat_o;
      if (done) begin
        done_cyc = cyc;
        check_val({nm, "_ready_at_done"}, ready, 1'b1);
        break;
      end
    end
    check_val({nm, "_done_cycle"}, done_cyc, DONE_CYC);
    check_val({nm, "_first_fall"}, first_fall, 5);
    check_val({nm, "_frame_count"}, nfr, NF);
    check_val({nm, "_data_in_low"}, bad_edge, 0);
    for (int f = 0; f < NF; f++) begin
      if (f == 1) expw = {1'b1, 1'b1, 8'hF0, 1'b0};
      else        expw = {1'b1, mk_par, mk, 1'b0};
      check_val($sformatf("%s_frame%0d", nm, f), frames[f], expw);
    end
  endtask

  initial begin
    int cnt;
    resetn = 1'b0;
    send   = 1'b0;
    letter = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", ready, 1'b1);
    check_val("rst_done", done, 1'b0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_clk", ps2_clk_o, 1'b1);
    check_val("rst_dat", ps2_dat_o, 1'b1);
    resetn = 1'b1;

    // A: 0x1C, parity 0
    request(5'd0);
    watch_seq("A", 8'h1C, 1'b0, 1'b0);
    @(negedge clk);
    check_val("A_done_width", done, 1'b0);

    // Z: 0x1A, parity 0
    request(5'd25);
    watch_seq("Z", 8'h1A, 1'b0, 1'b0);

    // E: 0x24, parity 1
    request(5'd4);
    watch_seq("E", 8'h24, 1'b1, 1'b0);

    // Out-of-range letter is rejected
    request(5'd26);
    @(negedge clk);
    check_val("bad_err_pulse", err, 1'b1);
    check_val("bad_ready", ready, 1'b1);
    check_val("bad_done", done, 1'b0);
    send = 1'b0;
    @(negedge clk);
    check_val("bad_err_width", err, 1'b0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done || !ready || !ps2_clk_o || !ps2_dat_o) cnt++;
    end
    check_val("bad_quiet", cnt, 0);

    // send held: second acceptance on the done cycle, then nothing more
    request(5'd0);
    watch_seq("hold1", 8'h1C, 1'b0, 1'b1);
    watch_seq("hold2", 8'h1C, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!ready || !ps2_clk_o) cnt++;
    end
    check_val("hold_no_third", cnt, 0);

    // Reset in the middle of a data bit
    request(5'd1);
    for (int cyc = 1; cyc < RST_CYC; cyc++) begin
      @(negedge clk);
      if (cyc == 1) send = 1'b0;
    end
    @(negedge clk);
    check_val("mid_busy", ready, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    check_val("mid_rst_clk", ps2_clk_o, 1'b1);
    check_val("mid_rst_dat", ps2_dat_o, 1'b1);
    check_val("mid_rst_ready", ready, 1'b1);
    check_val("mid_rst_done", done, 1'b0);
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!ps2_clk_o || !ps2_dat_o || done) cnt++;
    end
    check_val("mid_no_resume", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_letter_tx.md
# ps2_letter_tx

PS/2 device-side transmitter: the inverse of the keyboard receive path. It takes a 5-bit letter index (0 = A … 25 = Z) and serialises the matching PS/2 Set-2 scan codes onto PS/2 clock and data lines, generating the clock itself as a keyboard does. It sits in the loopback/self-test path, driving the Enigma keyboard input so the cipher chain can be exercised without a physical keyboard. It also serves as a bench stimulus source.

## Interface
- `CLK_DIV`, 2500: CLOCK_50 cycles per PS/2 clock half-period (2500 gives 10 kHz).
- `GAP`, 5000: idle CLOCK_50 cycles between frames of one sequence.

- `CLOCK_50` in 1: system clock; sole clock.
- `resetn` in 1: synchronous, active-low reset.
- `letter` in 5: letter index, sampled on acceptance.
- `send` in 1: request; accepted on an edge where `send & ready`.
- `ready` out 1: idle, able to accept; reset 1.
- `done` out 1: one-cycle pulse, sequence complete; reset 0.
- `err` out 1: one-cycle pulse, request rejected (`letter > 25`); reset 0.
- `ps2_clk_o` out 1: generated PS/2 clock; 1 = released; reset 1.
- `ps2_dat_o` out 1: PS/2 data; 1 = released; reset 1.

## Operation
- Scan-code table, A..Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
- Acceptance with `letter <= 25`:
  - Latch the code.
  - Drop `ready`.
  - Run the frame sequence.
- Acceptance with `letter > 25`:
  - `err` pulses in the next cycle.
  - No frames are sent.
  - `ready` stays 1.
- `send` while `ready`=0 is ignored; there is no queueing.
- Frame format, 11 bits: start 0, data bits 0–7 LSB first, odd parity (data + parity ones count is odd), stop 1.
- Bit cell is 2·CLK_DIV cycles:
  - First half: `ps2_dat_o` = bit and `ps2_clk_o` = 1.
  - Second half: `ps2_clk_o` = 0.
  - Data changes only while clock is high; the receiver samples on the falling edge.
- FSM states:
  - IDLE: on valid accept → FRAME.
  - FRAME: after the stop cell, → GAP if frames remain, else → IDLE.
  - GAP: after `GAP` cycles → FRAME.
- Frame sequence is make code, then F0, then make code (break), per Configuration.
- Counters:
  - Half-period counter is ⌈log2(CLK_DIV)⌉ bits and wraps at CLK_DIV−1.
  - Bit index counts 0..10.
  - Frame index counts 0..2.
- In GAP and IDLE both lines are released (1).
- `resetn`=0 at any point, including mid-frame:
  - Next edge: FSM in IDLE, all counters cleared.
  - Both lines at 1, `ready`=1, pulses at 0.
  - No partial frame resumes.

## Timing
- Accepting edge is cycle 0. Start bit is on `ps2_dat_o` from cycle 1; `ready`=0 from cycle 1.
- First falling `ps2_clk_o` edge is at cycle 1+CLK_DIV.
- One frame lasts 22·CLK_DIV cycles.
- `done` is high for exactly one cycle, the cycle after the last stop cell ends. This is cycle 1 + N·22·CLK_DIV + (N−1)·GAP, where N = number of frames.
- `ready` returns to 1 in the same cycle as `done`. A new request can be accepted on that edge.
- `err` and `done` never assert together.

## Configuration
- Macro `PS2_TX_BREAK_EN`.
- Defined: N = 3 (make, F0, make). The receiver sees a full press/release.
- Undefined: N = 1 (make only). The GAP state is unreachable and may be optimised out.

## Test plan
- CLK_DIV=4, GAP=8, break enabled, `letter`=0 (A):
  - Three frames: 1C (data 0,0,1,1,1,0,0,0, parity 0), F0 (parity 1), 1C.
  - `done` at cycle 281 (1 + 3·88 + 2·8).
- `letter`=25 (Z): data 0x1A (bits 0,1,0,1,1,0,0,0), parity 0; received through the keyboard receive path, it yields one-hot bit 25.
- `letter`=26 → `err` pulse at cycle 1, lines stay 1, `ready` stays 1, no `done`.
- `send` held high throughout a sequence:
  - Exactly one sequence per acceptance.
  - The second acceptance occurs on the `done` cycle.
- `resetn`=0 asserted mid-data-bit of the F0 frame:
  - Next cycle both lines are 1 and `ready`=1.
  - No further clock edges occur.
- Macro undefined, `letter`=4 (E):
  - Single 0x24 frame (bits 0,0,1,0,0,1,0,0, parity 1).
  - `done` at cycle 89.
